// File: rtl/operand_sequencer_if.sv
// Operand sequencer bus: raw switch/key inputs toward the sequencer and the
// registered operand set it presents to the arithmetic unit and display path.
interface operand_sequencer_if;
  logic [3:0] sw;
  logic       key_enter_n;
  logic       key_cancel_n;
  logic [3:0] X;
  logic [3:0] Y;
  logic [1:0] select;
  logic       valid;
  logic [1:0] state;

  // Board side: drives switches and buttons, observes the operand set
  modport master (
    output sw, key_enter_n, key_cancel_n,
    input  X, Y, select, valid, state
  );

  // Sequencer side: consumes switches and buttons, produces the operand set
  modport slave (
    input  sw, key_enter_n, key_cancel_n,
    output X, Y, select, valid, state
  );
endinterface

// File: rtl/operand_sequencer.sv
// Operand sequencer: synchronizes and debounces the enter/cancel buttons and
// walks X -> Y -> operation entry, holding a registered operand set for the
// combinational arithmetic unit. valid marks a complete, committed set.
module operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic             clk,
  input logic             reset,
  operand_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_X   = 2'd0,
    S_Y   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             enterMeta_q, enterSync_q;
  logic             cancelMeta_q, cancelSync_q;
  logic [3:0]       swMeta_q, swSync_q;

  logic             enterLevel_q, enterLevel_d;
  logic [CNT_W-1:0] enterCnt_q, enterCnt_d;
  logic             enterPress_q, enterPress_d;

  logic             cancelLevel_q, cancelLevel_d;
  logic [CNT_W-1:0] cancelCnt_q, cancelCnt_d;
  logic             cancelPress_q, cancelPress_d;

  state_t           state_q;
  logic [3:0]       x_q, y_q;
  logic [1:0]       select_q;
  logic             valid_q;

  // Two-flop synchronizers; keys idle high (released), switches idle low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enterMeta_q  <= 1'b1;
      enterSync_q  <= 1'b1;
      cancelMeta_q <= 1'b1;
      cancelSync_q <= 1'b1;
      swMeta_q     <= '0;
      swSync_q     <= '0;
    end else begin
      enterMeta_q  <= bus.key_enter_n;
      enterSync_q  <= enterMeta_q;
      cancelMeta_q <= bus.key_cancel_n;
      cancelSync_q <= cancelMeta_q;
      swMeta_q     <= bus.sw;
      swSync_q     <= swMeta_q;
    end
  end

  // Enter debounce: count consecutive disagreeing cycles, accept the new level
  // after DEBOUNCE_CYCLES of them, and flag a press only on a falling level
  always_comb begin
    enterLevel_d = enterLevel_q;
    enterCnt_d   = '0;
    enterPress_d = 1'b0;
    if (enterSync_q != enterLevel_q) begin
      if (enterCnt_q == CNT_LAST) begin
        enterLevel_d = enterSync_q;
        enterPress_d = ~enterSync_q;
      end else begin
        enterCnt_d = enterCnt_q + CNT_W'(1);
      end
    end
  end

  // Cancel debounce: same scheme as enter, fully independent
  always_comb begin
    cancelLevel_d = cancelLevel_q;
    cancelCnt_d   = '0;
    cancelPress_d = 1'b0;
    if (cancelSync_q != cancelLevel_q) begin
      if (cancelCnt_q == CNT_LAST) begin
        cancelLevel_d = cancelSync_q;
        cancelPress_d = ~cancelSync_q;
      end else begin
        cancelCnt_d = cancelCnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers; press pulses last exactly one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enterLevel_q  <= 1'b1;
      enterCnt_q    <= '0;
      enterPress_q  <= 1'b0;
      cancelLevel_q <= 1'b1;
      cancelCnt_q   <= '0;
      cancelPress_q <= 1'b0;
    end else begin
      enterLevel_q  <= enterLevel_d;
      enterCnt_q    <= enterCnt_d;
      enterPress_q  <= enterPress_d;
      cancelLevel_q <= cancelLevel_d;
      cancelCnt_q   <= cancelCnt_d;
      cancelPress_q <= cancelPress_d;
    end
  end

  // Entry sequence; cancel has priority and discards a coincident enter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_X;
      x_q      <= '0;
      y_q      <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
    end else if (cancelPress_q) begin
      state_q  <= S_X;
      x_q      <= '0;
      y_q      <= '0;
      select_q <= '0;
      valid_q  <= 1'b0;
    end else if (enterPress_q) begin
      case (state_q)
        S_X: begin
          x_q     <= swSync_q;
          state_q <= S_Y;
        end
        S_Y: begin
          y_q     <= swSync_q;
          state_q <= S_OP;
        end
        S_OP: begin
          select_q <= swSync_q[1:0];
          valid_q  <= 1'b1;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          valid_q <= 1'b0;
          state_q <= S_X;
        end
        default: begin
          state_q <= S_X;
        end
      endcase
    end
  end

  assign bus.X      = x_q;
  assign bus.Y      = y_q;
  assign bus.select = select_q;
  assign bus.valid  = valid_q;
  assign bus.state  = state_q;

endmodule
